// File: rtl/rf_pkg.sv
// Shared constants for the register-file writeback scheduler.
// Requester indices fix the writeback port order seen by the arbiter.
package rf_pkg;

    localparam int XLEN     = 32;
    localparam int AW       = 5;
    localparam int NUM_REGS = 32;

    localparam int REQ_ALU = 0;
    localparam int REQ_LD  = 1;
    localparam int REQ_MUL = 2;

    function automatic int rr_next(input int k, input int n);
        return (k + 1) % n;
    endfunction

endpackage

// File: rtl/regfile_wb_sched_rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant, pointer moves past the winner.
// Priority starts at the pointer and wraps modulo N.
module rr_arbiter
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] valid,
    output logic [N-1:0] grant
);

    import rf_pkg::*;

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        gidx  = ptr;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!found && valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                gidx        = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= PW'(rr_next(int'(gidx), N));
        end
    end

endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: round-robin access to the regfile write port,
// per-register busy scoreboard, RAW/WAW detection and a sticky error flag.
module regfile_wb_sched
#(
    parameter int N_REQ = 3,
    parameter int XLEN  = rf_pkg::XLEN,
    parameter int AW    = rf_pkg::AW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*AW-1:0]   req_addr,
    input  logic [N_REQ*XLEN-1:0] req_data,
    output logic [N_REQ-1:0]      req_ready,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_rd,
    output logic                  issue_ready,
    input  logic [AW-1:0]         rs1_addr,
    input  logic [AW-1:0]         rs2_addr,
    output logic                  raw_hazard,
    output logic                  WrEn_RF,
    output logic [AW-1:0]         WAddr_RF,
    output logic [XLEN-1:0]       WD_RF,
    output logic                  wb_err
);

    import rf_pkg::*;

    logic [N_REQ-1:0]    grant;
    logic                gnt_any;
    logic [AW-1:0]       sel_addr;
    logic [XLEN-1:0]     sel_data;
    logic                do_wr;
    logic                bad_wr;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (req_valid),
        .grant (grant)
    );

    assign req_ready = grant;
    assign gnt_any   = |grant;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // x0 writes are consumed but never reach the regfile
    assign do_wr  = gnt_any && (sel_addr != '0);
    assign bad_wr = do_wr && !busy[sel_addr];

    assign issue_ready = (issue_rd == '0) || !busy[issue_rd];
    assign raw_hazard  = ((rs1_addr != '0) && busy[rs1_addr]) ||
                         ((rs2_addr != '0) && busy[rs2_addr]);

    // clear first so a same-edge issue to the same register wins
    always_comb begin
        busy_nxt = busy;
        if (WrEn_RF) begin
            busy_nxt[WAddr_RF] = 1'b0;
        end
        if (issue_valid && issue_ready && (issue_rd != '0)) begin
            busy_nxt[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            WrEn_RF  <= 1'b0;
            WAddr_RF <= '0;
            WD_RF    <= '0;
            wb_err   <= 1'b0;
        end else begin
            busy    <= busy_nxt;
            WrEn_RF <= do_wr;
            if (do_wr) begin
                WAddr_RF <= sel_addr;
                WD_RF    <= sel_data;
            end
            if (bad_wr) begin
                wb_err <= 1'b1;
            end
        end
    end

endmodule
